// File: rtl/rv32i_types.sv
// Shared types for the cache-to-memory arbiter: FSM states, grant sides and line width.
package rv32i_types;

  localparam int unsigned LINE_WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    GAP
  } arb_state_t;

  typedef enum logic {
    GRANT_INST,
    GRANT_DATA
  } arb_grant_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of icache, dcache and memory line-port signals around the arbiter.
interface cache_arbiter_if
  import rv32i_types::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = LINE_WIDTH
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  // Arbiter view.
  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );

  // Caches plus memory view.
  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker; on a tie the side not granted last wins.
module rr_pick2
  import rv32i_types::*;
(
  input  logic [1:0] req,   // [0] = instruction side, [1] = data side
  input  arb_grant_t last,
  output arb_grant_t grant
);
  always_comb begin
    grant = GRANT_INST;
    case (req)
      2'b01:   grant = GRANT_INST;
      2'b10:   grant = GRANT_DATA;
      2'b11:   grant = (last == GRANT_DATA) ? GRANT_INST : GRANT_DATA;
      default: grant = GRANT_INST;
    endcase
  end
endmodule

// File: rtl/cache_arbiter.sv
// Shares one memory line port between icache and dcache, one latched burst at a time,
// round-robin on ties, with a one-cycle gap after each transaction.
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = LINE_WIDTH
) (
  input logic            clk,
  input logic            rst,
  cache_arbiter_if.slave bus
);
  arb_state_t        state_q, state_d;
  arb_grant_t        last_q, last_d;
  arb_grant_t        pick;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              i_pend, d_pend;

  assign i_pend = bus.i_read;
  assign d_pend = bus.d_read | bus.d_write;

  rr_pick2 u_pick (
    .req   ({d_pend, i_pend}),
    .last  (last_q),
    .grant (pick)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: begin
        if (i_pend || d_pend) begin
          last_d = pick;
          if (pick == GRANT_INST) begin
            state_d = SERVE_I;
            addr_d  = bus.i_addr;
            wr_d    = 1'b0;
          end else begin
            state_d = SERVE_D;
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
            wr_d    = bus.d_write;  // write wins over a simultaneous read
          end
        end
      end
      SERVE_I: if (bus.mem_resp) state_d = GAP;
      SERVE_D: if (bus.mem_resp) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= GRANT_DATA;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
    end
  end

  // Outputs decode from state_q only, so an async reset drops them at once.
  assign bus.mem_read  = (state_q == SERVE_I) || ((state_q == SERVE_D) && !wr_q);
  assign bus.mem_write = (state_q == SERVE_D) && wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_rdata   = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;
  assign bus.i_resp    = (state_q == SERVE_I) && bus.mem_resp;
  assign bus.d_resp    = (state_q == SERVE_D) && bus.mem_resp;

  a_no_rd_wr: assert property (@(posedge clk) disable iff (rst) !(bus.d_read && bus.d_write));
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: reset, lone reads/writes, latching, round-robin, gap.
module tb_cache_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [255:0] pat;

  cache_arbiter_if #(.ADDR_W(32), .LINE_W(256)) bus ();

  cache_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    pat           = {4{64'h0123_4567_89AB_CDEF}};
    rst           = 1'b1;
    bus.i_read    = 1'b0;
    bus.i_addr    = '0;
    bus.d_read    = 1'b0;
    bus.d_write   = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_resp  = 1'b0;
    #1;
    chk1("rst_mem_read", bus.mem_read, 1'b0);
    chk1("rst_mem_write", bus.mem_write, 1'b0);
    chk1("rst_i_resp", bus.i_resp, 1'b0);
    chk1("rst_d_resp", bus.d_resp, 1'b0);
    chkw("rst_mem_addr", 256'(bus.mem_addr), 256'h0);
    chkw("rst_mem_wdata", bus.mem_wdata, 256'h0);
    tick();
    tick();
    rst = 1'b0;

    // Lone icache read, memory answers on the third SERVE_I cycle.
    bus.i_addr = 32'h0000_0040;
    bus.i_read = 1'b1;
    tick();
    chk1("i_strobe_c1", bus.mem_read, 1'b1);
    chk1("i_nowrite", bus.mem_write, 1'b0);
    chkw("i_addr", 256'(bus.mem_addr), 256'h40);
    chk1("i_noresp_early", bus.i_resp, 1'b0);
    tick();
    chk1("i_strobe_c2", bus.mem_read, 1'b1);
    tick();
    bus.mem_rdata = {32{8'hAA}};
    bus.mem_resp  = 1'b1;
    #1;
    chk1("i_strobe_c3", bus.mem_read, 1'b1);
    chk1("i_resp", bus.i_resp, 1'b1);
    chkw("i_rdata", bus.i_rdata, {32{8'hAA}});
    chk1("i_no_d_resp", bus.d_resp, 1'b0);
    tick();
    bus.mem_resp = 1'b0;
    bus.i_read   = 1'b0;
    #1;
    chk1("i_gap_strobe", bus.mem_read, 1'b0);
    chk1("i_gap_resp", bus.i_resp, 1'b0);
    tick();
    chk1("i_idle_strobe", bus.mem_read, 1'b0);

    // Write-back with inputs changed after grant.
    bus.d_addr  = 32'h8000_0100;
    bus.d_wdata = pat;
    bus.d_write = 1'b1;
    tick();
    bus.d_wdata = ~pat;
    bus.d_addr  = 32'h0;
    #1;
    chk1("w_write", bus.mem_write, 1'b1);
    chk1("w_noread", bus.mem_read, 1'b0);
    chkw("w_addr", 256'(bus.mem_addr), 256'h8000_0100);
    chkw("w_wdata", bus.mem_wdata, pat);
    tick();
    chk1("w_write_c2", bus.mem_write, 1'b1);
    chkw("w_wdata_c2", bus.mem_wdata, pat);
    bus.mem_resp = 1'b1;
    #1;
    chk1("w_d_resp", bus.d_resp, 1'b1);
    chk1("w_no_i_resp", bus.i_resp, 1'b0);
    tick();
    bus.mem_resp = 1'b0;
    bus.d_write  = 1'b0;
    #1;
    chk1("w_gap_write", bus.mem_write, 1'b0);
    chk1("w_gap_resp", bus.d_resp, 1'b0);
    tick();

    // Async reset in the middle of a write-back.
    bus.d_addr  = 32'h0000_0100;
    bus.d_wdata = pat;
    bus.d_write = 1'b1;
    tick();
    chk1("ar_write_pre", bus.mem_write, 1'b1);
    #2;
    rst          = 1'b1;
    bus.mem_resp = 1'b1;
    #1;
    chk1("ar_write", bus.mem_write, 1'b0);
    chk1("ar_read", bus.mem_read, 1'b0);
    chk1("ar_d_resp", bus.d_resp, 1'b0);
    chk1("ar_i_resp", bus.i_resp, 1'b0);
    chkw("ar_addr", 256'(bus.mem_addr), 256'h0);
    rst          = 1'b0;
    bus.mem_resp = 1'b0;
    bus.d_write  = 1'b0;
    bus.d_read   = 1'b1;
    bus.d_addr   = 32'h0000_0200;
    tick();
    chk1("ar_d_read", bus.mem_read, 1'b1);
    chk1("ar_d_nowrite", bus.mem_write, 1'b0);
    chkw("ar_d_addr", 256'(bus.mem_addr), 256'h200);
    bus.mem_resp = 1'b1;
    #1;
    chk1("ar_d_resp2", bus.d_resp, 1'b1);
    tick();
    bus.mem_resp = 1'b0;
    bus.d_read   = 1'b0;
    tick();

    // Both sides requesting continuously from reset: I, D, I, D.
    rst = 1'b1;
    #1;
    rst        = 1'b0;
    bus.i_addr = 32'h0000_1000;
    bus.d_addr = 32'h0000_2000;
    bus.i_read = 1'b1;
    bus.d_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic exp_i;
      exp_i = (k % 2 == 0);
      tick();
      chkw($sformatf("rr%0d_addr", k), 256'(bus.mem_addr), exp_i ? 256'h1000 : 256'h2000);
      chk1($sformatf("rr%0d_read", k), bus.mem_read, 1'b1);
      bus.mem_rdata = {32{8'(k + 1)}};
      bus.mem_resp  = 1'b1;
      #1;
      chk1($sformatf("rr%0d_i_resp", k), bus.i_resp, exp_i);
      chk1($sformatf("rr%0d_d_resp", k), bus.d_resp, !exp_i);
      tick();
      bus.mem_resp = 1'b0;
      if (k == 3) begin
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
      end
      #1;
      chk1($sformatf("rr%0d_gap", k), bus.mem_read, 1'b0);
      tick();
      chk1($sformatf("rr%0d_idle", k), bus.mem_read, 1'b0);
    end

    // Spurious mem_resp in IDLE and in GAP; stale request held through GAP.
    bus.mem_resp = 1'b1;
    #1;
    chk1("sp_idle_i_resp", bus.i_resp, 1'b0);
    chk1("sp_idle_d_resp", bus.d_resp, 1'b0);
    tick();
    chk1("sp_idle_read", bus.mem_read, 1'b0);
    chk1("sp_idle_write", bus.mem_write, 1'b0);
    bus.mem_resp = 1'b0;
    bus.i_addr   = 32'h0000_3000;
    bus.i_read   = 1'b1;
    tick();
    chk1("st_read", bus.mem_read, 1'b1);
    chkw("st_addr", 256'(bus.mem_addr), 256'h3000);
    bus.mem_resp = 1'b1;
    #1;
    chk1("st_i_resp", bus.i_resp, 1'b1);
    tick();
    #1;
    chk1("st_gap_i_resp", bus.i_resp, 1'b0);
    chk1("st_gap_read", bus.mem_read, 1'b0);
    tick();
    bus.mem_resp = 1'b0;
    bus.i_read   = 1'b0;
    #1;
    chk1("st_idle_read", bus.mem_read, 1'b0);
    tick();
    chk1("st_no_regrant", bus.mem_read, 1'b0);
    chk1("st_no_resp", bus.i_resp, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
